// File: rtl/code_lock_pkg.sv
// Shared definitions for the code-lock transmitter: FSM states, button encoding
// and default timing.
package code_lock_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRESS,
        GAP,
        WAIT,
        DONE
    } tx_state_t;

    localparam logic BTN0 = 1'b0;
    localparam logic BTN1 = 1'b1;

    localparam int DEF_MAX_LEN     = 8;
    localparam int DEF_LEN_W       = 4;
    localparam int DEF_PRESS_CYC   = 4;
    localparam int DEF_GAP_CYC     = 4;
    localparam int DEF_TIMEOUT_CYC = 16;
    localparam int DEF_CNT_W       = 8;

endpackage

// File: rtl/code_tx_timer.sv
// Loadable down-counter shared by the press, gap and timeout phases.
// Saturates at zero; load has priority over decrement.
module code_tx_timer
    import code_lock_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/code_sender.sv
// Replays a stored code as timed button0/button1 presses into a code lock,
// then waits for the lock's unlock level and reports pass/fail.
module code_sender
    import code_lock_pkg::*;
#(
    parameter int MAX_LEN     = DEF_MAX_LEN,
    parameter int LEN_W       = DEF_LEN_W,
    parameter int PRESS_CYC   = DEF_PRESS_CYC,
    parameter int GAP_CYC     = DEF_GAP_CYC,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [MAX_LEN-1:0] code,
    input  logic [LEN_W-1:0]   code_len,
    input  logic               unlock_in,
    output logic               button0,
    output logic               button1,
    output logic               busy,
    output logic               done,
    output logic               pass
);

    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    tx_state_t          state, next_state;
    logic [MAX_LEN-1:0] code_q;
    logic [LEN_W-1:0]   len_q;
    logic [IDX_W-1:0]   idx, idx_next;
    logic               pass_next;
    logic               latch;
    logic [LEN_W-1:0]   len_clamped;
    logic [MAX_LEN-1:0] code_next;
    logic               press_bit;
    logic               last_bit;

    logic               tmr_load;
    logic               tmr_en;
    logic [CNT_W-1:0]   tmr_val;
    logic               tmr_zero;

    code_tx_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (tmr_en),
        .zero     (tmr_zero)
    );

    assign len_clamped = (code_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : code_len;
    assign last_bit    = (LEN_W'(idx) == (len_q - LEN_W'(1)));

    always_comb begin
        next_state = state;
        idx_next   = idx;
        pass_next  = pass;
        latch      = 1'b0;
        tmr_load   = 1'b0;
        tmr_en     = 1'b0;
        tmr_val    = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    pass_next = 1'b0;
                    tmr_load  = 1'b1;
                    if (code_len != '0) begin
                        latch      = 1'b1;
                        idx_next   = '0;
                        tmr_val    = CNT_W'(PRESS_CYC - 1);
                        next_state = PRESS;
                    end else begin
                        tmr_val    = CNT_W'(TIMEOUT_CYC - 1);
                        next_state = WAIT;
                    end
                end
            end
            PRESS: begin
                if (!tmr_zero) begin
                    tmr_en = 1'b1;
                end else begin
                    tmr_load   = 1'b1;
                    tmr_val    = CNT_W'(GAP_CYC - 1);
                    next_state = GAP;
                end
            end
            GAP: begin
                if (!tmr_zero) begin
                    tmr_en = 1'b1;
                end else if (last_bit) begin
                    tmr_load   = 1'b1;
                    tmr_val    = CNT_W'(TIMEOUT_CYC - 1);
                    next_state = WAIT;
                end else begin
                    idx_next   = idx + IDX_W'(1);
                    tmr_load   = 1'b1;
                    tmr_val    = CNT_W'(PRESS_CYC - 1);
                    next_state = PRESS;
                end
            end
            WAIT: begin
                // Unlock wins over the timeout, so the final wait cycle still passes.
                if (unlock_in) begin
                    pass_next  = 1'b1;
                    next_state = DONE;
                end else if (tmr_zero) begin
                    pass_next  = 1'b0;
                    next_state = DONE;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register.
    assign code_next = latch ? code : code_q;
    assign press_bit = code_next[idx_next];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            code_q  <= '0;
            len_q   <= '0;
            idx     <= '0;
            pass    <= 1'b0;
            button0 <= 1'b0;
            button1 <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state <= next_state;
            idx   <= idx_next;
            pass  <= pass_next;
            if (latch) begin
                code_q <= code;
                len_q  <= len_clamped;
            end
            button0 <= (next_state == PRESS) && (press_bit == BTN0);
            button1 <= (next_state == PRESS) && (press_bit == BTN1);
            busy    <= (next_state == PRESS) || (next_state == GAP) || (next_state == WAIT);
            done    <= (next_state == DONE);
        end
    end

endmodule

// File: tb/tb_code_sender.sv
// Self-checking bench for code_sender with a behavioural 0,1,0 lock and a
// timeline model of the expected press/wait/done sequence.
module tb_code_sender;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] code = '0;
    logic [3:0] code_len = '0;
    logic       unlock_in;
    logic       button0, button1, busy, done, pass;

    logic       lock_open = 1'b0;
    logic       force_open = 1'b0;
    logic       lock_clear = 1'b0;
    logic       prev0 = 1'b0;
    logic       prev1 = 1'b0;
    logic [2:0] hist = '0;
    int         hcnt = 0;

    int checks = 0;
    int errors = 0;

    code_sender dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .code      (code),
        .code_len  (code_len),
        .unlock_in (unlock_in),
        .button0   (button0),
        .button1   (button1),
        .busy      (busy),
        .done      (done),
        .pass      (pass)
    );

    always #5 clk = ~clk;

    assign unlock_in = lock_open | force_open;

    // Behavioural lock: opens when the last three presses were 0,1,0.
    always @(posedge clk) begin
        prev0 <= button0;
        prev1 <= button1;
        if (!rst_n || lock_clear) begin
            hist      <= '0;
            hcnt      <= 0;
            lock_open <= 1'b0;
        end else if ((button0 && !prev0) || (button1 && !prev1)) begin
            hist      <= {hist[1:0], button1};
            hcnt      <= (hcnt < 3) ? hcnt + 1 : 3;
            lock_open <= (hcnt >= 2) && ({hist[1:0], button1} == 3'b010);
        end
    end

    always @(negedge clk) begin
        if (rst_n && button0 && button1) begin
            $display("[TB] FAIL exclusive_buttons: both high at %0t", $time);
            errors++;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // force_off: -1 = unlock forced before start, >=1000 = never forced,
    // otherwise cycle offset after the accepting edge where it is forced high.
    task automatic applyStimulus(input logic [7:0] c, input logic [3:0] len,
                                 input int force_off, input bit mid_start, input string name);
        int n, k, kf, d;
        bit opens, pass_exp;
        logic [3:0] exp;
        n = (len > 4'd8) ? 8 : int'(len);
        opens = (n >= 3) && (c[n-3] == 1'b0) && (c[n-2] == 1'b1) && (c[n-1] == 1'b0);
        k = 1000;
        if (opens) k = 0;
        if (force_off < 0) begin
            k = 0;
        end else if (force_off < 1000) begin
            kf = force_off - 8 * n;
            if (kf < 0) kf = 0;
            if (kf < k) k = kf;
        end
        pass_exp = (k <= 15);
        d = 8 * n + (pass_exp ? k + 1 : 16);

        @(negedge clk);
        lock_clear = 1'b1;
        if (force_off < 0) force_open = 1'b1;
        @(negedge clk);
        lock_clear = 1'b0;
        start = 1'b1;
        code = c;
        code_len = len;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int cyc = 0; cyc <= d + 2; cyc++) begin
            if (cyc == force_off) force_open = 1'b1;
            if (cyc == 1) begin
                code = 8'($urandom);
                code_len = 4'($urandom);
            end
            if (mid_start && cyc == 4) begin
                start = 1'b1;
                code = ~c;
                code_len = 4'd5;
            end
            if (cyc == 5) start = 1'b0;
            exp = 4'b0000;
            if (cyc < d) begin
                exp[1] = 1'b1;
                if (cyc < 8 * n && (cyc % 8) < 4) begin
                    if (c[cyc/8]) exp[2] = 1'b1;
                    else          exp[3] = 1'b1;
                end
            end else if (cyc == d) begin
                exp[0] = 1'b1;
            end
            checkOutput($sformatf("%s_c%0d_b0b1busydone", name, cyc),
                        {28'd0, button0, button1, busy, done}, {28'd0, exp});
            if (cyc >= d)
                checkOutput($sformatf("%s_c%0d_pass", name, cyc), {31'd0, pass}, {31'd0, pass_exp});
            @(posedge clk);
            #1;
        end
        force_open = 1'b0;
    endtask

    task automatic midReset();
        @(negedge clk);
        lock_clear = 1'b1;
        @(negedge clk);
        lock_clear = 1'b0;
        start = 1'b1;
        code = 8'b0000_0010;
        code_len = 4'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int cyc = 0; cyc < 9; cyc++) begin
            @(posedge clk);
            #1;
        end
        checkOutput("rst_pre_press", {28'd0, button0, button1, busy, done}, 32'h4 | 32'h2);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        checkOutput("rst_mid_outputs", {28'd0, button0, button1, busy, done}, 32'h0);
        for (int cyc = 0; cyc < 45; cyc++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("rst_idle_c%0d", cyc), {28'd0, button0, button1, busy, done}, 32'h0);
        end
    endtask

    initial begin
        int fo;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_outputs", {28'd0, button0, button1, busy, done}, 32'h0);
        checkOutput("reset_pass", {31'd0, pass}, 32'h0);
        rst_n = 1'b1;

        applyStimulus(8'b0000_0010, 4'd3, 1000, 1'b0, "seq010");
        applyStimulus(8'b0000_0111, 4'd3, 1000, 1'b0, "seq111");
        applyStimulus(8'h00, 4'd0, -1, 1'b0, "len0_open");
        applyStimulus(8'h00, 4'd0, 1000, 1'b0, "len0_closed");
        applyStimulus(8'b0000_0010, 4'd3, 1000, 1'b1, "mid_start");
        midReset();
        applyStimulus(8'b0000_0010, 4'd3, 1000, 1'b0, "after_reset");
        applyStimulus(8'b0000_0111, 4'd3, 39, 1'b0, "tmo_last_cycle");
        applyStimulus(8'b0000_0111, 4'd3, 40, 1'b0, "tmo_missed");
        applyStimulus(8'hA5, 4'd15, 1000, 1'b0, "clamp_fail");
        applyStimulus(8'h4C, 4'd12, 1000, 1'b0, "clamp_pass");

        for (int t = 0; t < 8; t++) begin
            case ($urandom_range(0, 2))
                0:       fo = 1000;
                1:       fo = -1;
                default: fo = int'($urandom_range(0, 90));
            endcase
            applyStimulus(8'($urandom), 4'($urandom), fo, 1'($urandom), $sformatf("rand%0d", t));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
